// File: rtl/digital_pfd_if.sv
// digital_pfd_if: groups the clock inputs and the detector outputs of
// digital_pfd into one bundle.
//   master : drives clk_ref/clk_fb, observes the detector outputs
//   slave  : the detector itself
// Signals: clk_ref, clk_fb (async clocks sampled as data), up, dn,
//          phase_err (signed CNT_W), err_valid, locked.
interface digital_pfd_if #(
  parameter int unsigned CNT_W = 8
);
  logic                    clk_ref;
  logic                    clk_fb;
  logic                    up;
  logic                    dn;
  logic signed [CNT_W-1:0] phase_err;
  logic                    err_valid;
  logic                    locked;

  modport master (
    output clk_ref, clk_fb,
    input  up, dn, phase_err, err_valid, locked
  );

  modport slave (
    input  clk_ref, clk_fb,
    output up, dn, phase_err, err_valid, locked
  );
endinterface

// File: rtl/digital_pfd.sv
// digital_pfd: sampled phase-frequency detector. Oversamples clk_ref and the
// divided feedback clk_fb on clk_sys, measures the distance between their
// rising edges in clk_sys cycles and reports it as a signed word, with
// UP/DN pulses and a lock indicator.
// Ports:
//   clk_sys - sampling clock, all logic on its rising edge
//   rst_n   - synchronous active-low reset
//   bus     - digital_pfd_if.slave: clk_ref, clk_fb in; up, dn, phase_err,
//             err_valid, locked out
// Optional: define DPFD_TIMEOUT_EN to abort a window whose count saturates
// (reports +/-saturation and drops lock); otherwise the count holds at
// saturation until the opposite edge arrives.
module digital_pfd #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_THRESH = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input logic          clk_sys,
  input logic          rst_n,
  digital_pfd_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-2:0]  CNT_SAT  = '1;
  localparam logic [CNT_W-2:0]  CNT_ONE  = {{(CNT_W-2){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(LOCK_THRESH);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {IDLE, UP, DN} state_t;

  // synchronizers and edge history
  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic                   ref_hist, fb_hist;
  logic                   rise_ref, rise_fb;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_hist <= 1'b0;
      fb_hist  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], bus.clk_ref};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], bus.clk_fb};
      ref_hist <= ref_sync[SYNC_STAGES-1];
      fb_hist  <= fb_sync[SYNC_STAGES-1];
    end
  end

  assign rise_ref = ref_sync[SYNC_STAGES-1] & ~ref_hist;
  assign rise_fb  = fb_sync[SYNC_STAGES-1] & ~fb_hist;

  // window FSM
  state_t           state, state_nx;
  logic [CNT_W-2:0] count, count_nx;
  logic [CNT_W-1:0] cnt_ext;
  logic [CNT_W-1:0] pe_q, pe_nx;
  logic             ev_q, ev_nx;
  logic             tmo_q, tmo_nx;
  logic             up_q, dn_q;

  assign cnt_ext = {1'b0, count};

  always_comb begin
    state_nx = state;
    count_nx = count;
    pe_nx    = pe_q;
    ev_nx    = 1'b0;
    tmo_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (rise_ref && rise_fb) begin
          ev_nx = 1'b1;
          pe_nx = '0;
        end else if (rise_ref) begin
          state_nx = UP;
          count_nx = CNT_ONE;
        end else if (rise_fb) begin
          state_nx = DN;
          count_nx = CNT_ONE;
        end
      end
      UP: begin
        if (rise_fb) begin
          ev_nx = 1'b1;
          pe_nx = cnt_ext;
          // a ref edge coinciding with the closing fb edge opens the next window
          if (rise_ref) begin
            state_nx = UP;
            count_nx = CNT_ONE;
          end else begin
            state_nx = IDLE;
            count_nx = '0;
          end
        end else if (count == CNT_SAT) begin
`ifdef DPFD_TIMEOUT_EN
          ev_nx    = 1'b1;
          pe_nx    = cnt_ext;
          tmo_nx   = 1'b1;
          state_nx = IDLE;
          count_nx = '0;
`else
          count_nx = count;
`endif
        end else begin
          count_nx = count + 1'b1;
        end
      end
      DN: begin
        if (rise_ref) begin
          ev_nx = 1'b1;
          pe_nx = -cnt_ext;
          if (rise_fb) begin
            state_nx = DN;
            count_nx = CNT_ONE;
          end else begin
            state_nx = IDLE;
            count_nx = '0;
          end
        end else if (count == CNT_SAT) begin
`ifdef DPFD_TIMEOUT_EN
          ev_nx    = 1'b1;
          pe_nx    = -cnt_ext;
          tmo_nx   = 1'b1;
          state_nx = IDLE;
          count_nx = '0;
`else
          count_nx = count;
`endif
        end else begin
          count_nx = count + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      pe_q  <= '0;
      ev_q  <= 1'b0;
      tmo_q <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pe_q  <= pe_nx;
      ev_q  <= ev_nx;
      tmo_q <= tmo_nx;
      up_q  <= (state_nx == UP);
      dn_q  <= (state_nx == DN);
    end
  end

  // lock detect, evaluated on the registered strobe so locked follows it by one cycle
  logic [GOOD_W-1:0] good;
  logic              locked_q;
  logic [CNT_W-1:0]  pe_mag;
  logic              in_thresh;

  assign pe_mag    = pe_q[CNT_W-1] ? -pe_q : pe_q;
  assign in_thresh = (pe_mag <= THRESH);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      good     <= '0;
      locked_q <= 1'b0;
    end else if (ev_q) begin
      if (tmo_q || !in_thresh) begin
        good     <= '0;
        locked_q <= 1'b0;
      end else if (good != GOOD_MAX) begin
        good     <= good + 1'b1;
        locked_q <= ((good + 1'b1) == GOOD_MAX);
      end else begin
        locked_q <= 1'b1;
      end
    end
  end

  assign bus.up        = up_q;
  assign bus.dn        = dn_q;
  assign bus.phase_err = pe_q;
  assign bus.err_valid = ev_q;
  assign bus.locked    = locked_q;

endmodule
